// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and multi-cycle MDU freeze.
// Optional performance counters are enabled with `define HAZARD_CTRL_PERF_CNT_EN.
package hazard_controller_pkg;
  typedef logic [4:0] reg_t;
endpackage

module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  reg_t             i_ID_rnum1,
  input  reg_t             i_ID_rnum2,
  input  logic             i_ID_ren1,
  input  logic             i_ID_ren2,
  input  reg_t             i_EX_wnum,
  input  logic             i_EX_mem_read,
  input  logic             i_EX_branch_taken,
  input  logic             i_EX_mdu_start,
  input  logic             i_mdu_done,
  output logic             o_PC_stall,
  output logic             o_IFID_stall,
  output logic             o_IDEX_stall,
  output logic             o_IDEX_bubble,
  output logic             o_EXMEM_bubble,
  output logic             o_IFID_flush,
`ifdef HAZARD_CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt,
`endif
  output logic             o_mdu_busy
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t state, next_state;
  logic   load_use;
  logic   mdu_stall;
  logic   lu_stall;
  logic   flush;
  logic   busy;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= RUN;
    else         state <= next_state;
  end

  assign load_use = i_EX_mem_read && (i_EX_wnum != '0) &&
                    ((i_ID_ren1 && (i_ID_rnum1 == i_EX_wnum)) ||
                     (i_ID_ren2 && (i_ID_rnum2 == i_EX_wnum)));

  // Priority in RUN: wrong-path squash, then MDU freeze, then load-use bubble.
  always_comb begin
    next_state = state;
    mdu_stall  = 1'b0;
    lu_stall   = 1'b0;
    flush      = 1'b0;
    busy       = 1'b0;
    case (state)
      RUN: begin
        if (i_EX_branch_taken) begin
          flush = 1'b1;
        end else if (i_EX_mdu_start && !i_mdu_done) begin
          mdu_stall  = 1'b1;
          next_state = MDU_WAIT;
        end else if (load_use) begin
          lu_stall = 1'b1;
        end
      end
      MDU_WAIT: begin
        busy = 1'b1;
        if (i_mdu_done) next_state = RUN;
        else            mdu_stall  = 1'b1;
      end
      default: next_state = RUN;
    endcase
  end

  // Gated by reset so every output is low while i_rstn is held.
  assign o_PC_stall     = i_rstn && (mdu_stall || lu_stall);
  assign o_IFID_stall   = i_rstn && (mdu_stall || lu_stall);
  assign o_IDEX_stall   = i_rstn && mdu_stall;
  assign o_IDEX_bubble  = i_rstn && (lu_stall || flush);
  assign o_EXMEM_bubble = i_rstn && mdu_stall;
  assign o_IFID_flush   = i_rstn && flush;
  assign o_mdu_busy     = i_rstn && busy;

`ifdef HAZARD_CTRL_PERF_CNT_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_PC_stall)   o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      if (o_IFID_flush) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
